sqrt_shift_reg: RTL and testbench



---
 rtl/sqrt_shift_reg.sv | 104 ++++++++++
 tb/tb_sqrt_shift_reg.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/sqrt_shift_reg.sv
// sqrt_shift_reg: WIDTH-bit multi-mode shift register that feeds radicand
// bit pairs into the square-root datapath (SHIFT=2 gives one pair per step).
// Modes: 00 hold, 01 parallel load, 10 shift left, 11 shift right.
// cnt counts the shifts left before all loaded data has left the register.
// done pulses for one cycle on the shift that takes cnt from 1 to 0.
// Optional build macro SHREG_ROTATE_EN: the shift modes rotate instead,
// and sin is ignored.
module sqrt_shift_reg #(
    parameter int unsigned              WIDTH = 8,
    parameter int unsigned              SHIFT = 2,
    parameter logic [WIDTH-1:0]         INIT  = '0,
    localparam int unsigned             CW    = $clog2(WIDTH/SHIFT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic [SHIFT-1:0] sin,
    output logic [WIDTH-1:0] q,
    output logic [SHIFT-1:0] sout_msb,
    output logic [SHIFT-1:0] sout_lsb,
    output logic [CW-1:0]    cnt,
    output logic             empty,
    output logic             done
);

    localparam logic [1:0]    MODE_HOLD  = 2'b00;
    localparam logic [1:0]    MODE_LOAD  = 2'b01;
    localparam logic [1:0]    MODE_LEFT  = 2'b10;
    localparam logic [1:0]    MODE_RIGHT = 2'b11;
    localparam logic [CW-1:0] LOAD_CNT   = CW'(WIDTH / SHIFT);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    // A misconfigured instance must not build silently.
    generate
        if (SHIFT < 1 || (WIDTH % SHIFT) != 0 || SHIFT > WIDTH / 2) begin : g_bad_params
            $error("sqrt_shift_reg: WIDTH must be a multiple of SHIFT and SHIFT in 1..WIDTH/2");
        end
    endgenerate

    logic [WIDTH-1:0] q_left;
    logic [WIDTH-1:0] q_right;
    logic [CW-1:0]    cnt_dec;

    // Next-value candidates for the two shift directions and the saturating count.
    always_comb begin
`ifdef SHREG_ROTATE_EN
        q_left  = {q[WIDTH-SHIFT-1:0], q[WIDTH-1 -: SHIFT]};
        q_right = {q[SHIFT-1:0], q[WIDTH-1:SHIFT]};
`else
        q_left  = {q[WIDTH-SHIFT-1:0], sin};
        q_right = {sin, q[WIDTH-1:SHIFT]};
`endif
        cnt_dec = (cnt == '0) ? '0 : cnt - CNT_ONE;
    end

`ifdef SHREG_ROTATE_EN
    // Serial input has no role when rotating.
    logic sin_unused;
    assign sin_unused = ^sin;
`endif

    // Register, counter and done pulse; reset wins over every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            q    <= INIT;
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (en) begin
                case (mode)
                    MODE_HOLD: begin
                    end
                    MODE_LOAD: begin
                        q   <= d;
                        cnt <= LOAD_CNT;
                    end
                    MODE_LEFT: begin
                        q    <= q_left;
                        cnt  <= cnt_dec;
                        done <= (cnt == CNT_ONE);
                    end
                    MODE_RIGHT: begin
                        q    <= q_right;
                        cnt  <= cnt_dec;
                        done <= (cnt == CNT_ONE);
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Serial taps and empty flag are pure decodes of the registered state.
    always_comb begin
        sout_msb = q[WIDTH-1 -: SHIFT];
        sout_lsb = q[SHIFT-1:0];
        empty    = (cnt == '0);
    end

endmodule

// File: tb/tb_sqrt_shift_reg.sv
// Directed bench for sqrt_shift_reg (WIDTH=8, SHIFT=2, INIT=0): a table of
// single-cycle operations with hand-computed results, then hand-written
// mid-sequence reset and reload cases. Build with SHREG_ROTATE_EN defined
// to exercise the rotate table instead of the shift table.
module tb_sqrt_shift_reg;

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [7:0] d;
    logic [1:0] sin;
    logic [7:0] q;
    logic [1:0] sout_msb;
    logic [1:0] sout_lsb;
    logic [2:0] cnt;
    logic       empty;
    logic       done;

    int errors = 0;
    int checks = 0;

    sqrt_shift_reg #(.WIDTH(8), .SHIFT(2), .INIT(8'h00)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .mode     (mode),
        .d        (d),
        .sin      (sin),
        .q        (q),
        .sout_msb (sout_msb),
        .sout_lsb (sout_lsb),
        .cnt      (cnt),
        .empty    (empty),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       en;
        logic [1:0] mode;
        logic [7:0] d;
        logic [1:0] sin;
        logic [7:0] q_exp;
        logic [2:0] cnt_exp;
        logic       done_exp;
    } vec_t;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one operation away from the edge, then sample 1 time unit after it.
    task automatic step(input logic r, input logic e, input logic [1:0] m,
                        input logic [7:0] dd, input logic [1:0] s);
        @(negedge clk);
        rst = r; en = e; mode = m; d = dd; sin = s;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [7:0] qe,
                             input logic [2:0] ce, input logic de);
        logic [7:0] msb_e;
        logic [7:0] lsb_e;
        msb_e = {6'b0, qe[7:6]};
        lsb_e = {6'b0, qe[1:0]};
        check({tag, ".q"},        q,                qe);
        check({tag, ".cnt"},      {5'b0, cnt},      {5'b0, ce});
        check({tag, ".empty"},    {7'b0, empty},    {7'b0, (ce == 3'd0)});
        check({tag, ".done"},     {7'b0, done},     {7'b0, de});
        check({tag, ".sout_msb"}, {6'b0, sout_msb}, msb_e);
        check({tag, ".sout_lsb"}, {6'b0, sout_lsb}, lsb_e);
    endtask

    vec_t vecs[$];

    initial begin
        rst = 1'b1; en = 1'b0; mode = 2'b00; d = 8'h00; sin = 2'b00;

`ifdef SHREG_ROTATE_EN
        vecs.push_back('{1, 1, 2'b01, 8'hFF, 2'b00, 8'h00, 3'd0, 0});
        vecs.push_back('{0, 1, 2'b01, 8'hB4, 2'b00, 8'hB4, 3'd4, 0});
        vecs.push_back('{0, 1, 2'b10, 8'h00, 2'b01, 8'hD2, 3'd3, 0});
        vecs.push_back('{0, 1, 2'b10, 8'h00, 2'b11, 8'h4B, 3'd2, 0});
        vecs.push_back('{0, 1, 2'b10, 8'h00, 2'b00, 8'h2D, 3'd1, 0});
        vecs.push_back('{0, 1, 2'b10, 8'h00, 2'b00, 8'hB4, 3'd0, 1});
        vecs.push_back('{0, 1, 2'b11, 8'h00, 2'b11, 8'h2D, 3'd0, 0});
        vecs.push_back('{0, 0, 2'b10, 8'h00, 2'b00, 8'h2D, 3'd0, 0});
        vecs.push_back('{0, 1, 2'b01, 8'h5A, 2'b00, 8'h5A, 3'd4, 0});
        vecs.push_back('{0, 1, 2'b11, 8'h00, 2'b11, 8'h96, 3'd3, 0});
`else
        vecs.push_back('{1, 1, 2'b01, 8'hFF, 2'b00, 8'h00, 3'd0, 0});
        vecs.push_back('{0, 1, 2'b01, 8'hB4, 2'b00, 8'hB4, 3'd4, 0});
        vecs.push_back('{0, 1, 2'b10, 8'h00, 2'b01, 8'hD1, 3'd3, 0});
        vecs.push_back('{0, 1, 2'b01, 8'hB4, 2'b00, 8'hB4, 3'd4, 0});
        vecs.push_back('{0, 1, 2'b10, 8'h00, 2'b00, 8'hD0, 3'd3, 0});
        vecs.push_back('{0, 1, 2'b10, 8'h00, 2'b00, 8'h40, 3'd2, 0});
        vecs.push_back('{0, 1, 2'b10, 8'h00, 2'b00, 8'h00, 3'd1, 0});
        vecs.push_back('{0, 1, 2'b10, 8'h00, 2'b00, 8'h00, 3'd0, 1});
        vecs.push_back('{0, 1, 2'b10, 8'h00, 2'b00, 8'h00, 3'd0, 0});
        vecs.push_back('{0, 1, 2'b01, 8'h5A, 2'b00, 8'h5A, 3'd4, 0});
        vecs.push_back('{0, 0, 2'b10, 8'h00, 2'b11, 8'h5A, 3'd4, 0});
        vecs.push_back('{0, 0, 2'b10, 8'h00, 2'b11, 8'h5A, 3'd4, 0});
        vecs.push_back('{0, 0, 2'b10, 8'h00, 2'b11, 8'h5A, 3'd4, 0});
        vecs.push_back('{0, 1, 2'b11, 8'h00, 2'b11, 8'hD6, 3'd3, 0});
        vecs.push_back('{0, 1, 2'b00, 8'hFF, 2'b11, 8'hD6, 3'd3, 0});
        vecs.push_back('{0, 1, 2'b11, 8'h00, 2'b00, 8'h35, 3'd2, 0});
        vecs.push_back('{0, 1, 2'b11, 8'h00, 2'b10, 8'h8D, 3'd1, 0});
        vecs.push_back('{0, 1, 2'b11, 8'h00, 2'b00, 8'h23, 3'd0, 1});
        vecs.push_back('{0, 1, 2'b11, 8'h00, 2'b01, 8'h48, 3'd0, 0});
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].en, vecs[i].mode, vecs[i].d, vecs[i].sin);
            check_all($sformatf("vec%0d", i), vecs[i].q_exp, vecs[i].cnt_exp, vecs[i].done_exp);
        end

        // Reset two shifts into a sequence: aborted, no done afterwards.
        step(0, 1, 2'b01, 8'hB4, 2'b00);
        step(0, 1, 2'b10, 8'h00, 2'b00);
        step(0, 1, 2'b10, 8'h00, 2'b00);
        check("midrst.pre_cnt", {5'b0, cnt}, 8'd2);
        step(1, 1, 2'b10, 8'h00, 2'b11);
        check_all("midrst", 8'h00, 3'd0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(0, 1, 2'b10, 8'h00, 2'b00);
            check($sformatf("midrst.after%0d.done", k), {7'b0, done}, 8'h00);
            check($sformatf("midrst.after%0d.cnt", k), {5'b0, cnt}, 8'h00);
        end

        // Reload at cnt==1 restarts the count without a done pulse.
        step(0, 1, 2'b01, 8'hB4, 2'b00);
        step(0, 1, 2'b10, 8'h00, 2'b00);
        step(0, 1, 2'b10, 8'h00, 2'b00);
        step(0, 1, 2'b10, 8'h00, 2'b00);
        check("reload.pre_cnt", {5'b0, cnt}, 8'd1);
        step(0, 1, 2'b01, 8'h3C, 2'b00);
        check_all("reload", 8'h3C, 3'd4, 1'b0);
        step(0, 1, 2'b00, 8'h00, 2'b00);
        check_all("reload.hold", 8'h3C, 3'd4, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
